code_length_decoder: RTL and testbench



---
 rtl/code_length_decoder.sv | 136 +++++++++++++
 tb/tb_code_length_decoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_length_decoder.sv
// code_length_decoder: expands DEFLATE code-length alphabet symbols
// (0-18 + extra bits) into the flat per-symbol code-length sequence.
module code_length_decoder #(
   parameter int LEN_W     = 4,
   parameter int IDX_W     = 9,
   parameter int MAX_TOTAL = 320
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] total_count,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_sym,
   input  logic [6:0]       in_extra,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEN_W-1:0] out_len,
   output logic [IDX_W-1:0] out_index,
   output logic             done,
   output logic             error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EMIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   // longest run is 11+127 = 138
   localparam int RUN_W = 8;
   localparam logic [IDX_W-1:0] MAX_T = IDX_W'(MAX_TOTAL);

   logic [2:0]       state;
   logic [IDX_W-1:0] total;
   logic [IDX_W-1:0] index;
   logic [RUN_W-1:0] run;
   logic [LEN_W-1:0] val;
   logic [LEN_W-1:0] prev_len;

   logic [RUN_W-1:0] dec_run;
   logic [LEN_W-1:0] dec_val;
   logic             dec_bad;
   logic [IDX_W:0]   dec_end;
   logic             bad_total;
   logic             last_idx;

   assign bad_total = (total_count == '0) || (total_count > MAX_T);
   assign last_idx  = (index + IDX_W'(1)) == total;

   // decode the offered symbol into run length, value and legality
   always_comb begin
      dec_run = RUN_W'(1);
      dec_val = '0;
      dec_bad = 1'b0;
      unique case (1'b1)
         (in_sym < 5'd16): begin
            dec_run = RUN_W'(1);
            dec_val = LEN_W'(in_sym[3:0]);
         end
         (in_sym == 5'd16): begin
            dec_run = RUN_W'(3) + RUN_W'(in_extra[1:0]);
            dec_val = prev_len;
            dec_bad = (index == '0);
         end
         (in_sym == 5'd17): begin
            dec_run = RUN_W'(3) + RUN_W'(in_extra[2:0]);
         end
         (in_sym == 5'd18): begin
            dec_run = RUN_W'(11) + RUN_W'(in_extra);
         end
         (in_sym > 5'd18): begin
            dec_bad = 1'b1;
         end
      endcase
      // one extra bit so index+run never wraps
      dec_end = {1'b0, index} + (IDX_W+1)'(dec_run);
      if (dec_end > {1'b0, total}) dec_bad = 1'b1;
   end

   assign in_ready  = (state == S_FETCH);
   assign out_valid = (state == S_EMIT);
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERR);
   assign out_len   = val;
   assign out_index = index;

   // control FSM and run/index bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         total    <= '0;
         index    <= '0;
         run      <= '0;
         val      <= '0;
         prev_len <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  if (bad_total) begin
                     state <= S_ERR;
                  end else begin
                     total    <= total_count;
                     index    <= '0;
                     prev_len <= '0;
                     state    <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (in_valid) begin
                  if (dec_bad) begin
                     state <= S_ERR;
                  end else begin
                     run   <= dec_run;
                     val   <= dec_val;
                     state <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  index    <= index + IDX_W'(1);
                  run      <= run - RUN_W'(1);
                  prev_len <= val;
                  if (run == RUN_W'(1))
                     state <= last_idx ? S_DONE : S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_code_length_decoder.sv
// tb_code_length_decoder: table vectors, hand sequences and random
// streams checked against a queue-based expansion model.
module tb_code_length_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [8:0] total_count;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_sym;
   logic [6:0] in_extra;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_len;
   logic [8:0] out_index;
   logic       done;
   logic       error;

   int compared   = 0;
   int mismatched = 0;

   int cur_syms[$];
   int cur_ext[$];
   int exp_q[$];
   int exp_err;

   typedef struct {
      string nm;
      int    total;
      int    mode;
      int    n;
      int    s[5];
      int    e[5];
      int    cnt;
      int    err;
      int    sum;
   } vec_t;

   vec_t tab[$];

   code_length_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .total_count (total_count),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sym      (in_sym),
      .in_extra    (in_extra),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_len     (out_len),
      .out_index   (out_index),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // reference: expand symbols into the flat length list
   function automatic void build_expect(input int total);
      int idx, prev, run, val, s, e;
      idx = 0;
      prev = 0;
      exp_q.delete();
      exp_err = 0;
      if (total == 0 || total > 320) begin
         exp_err = 1;
         return;
      end
      foreach (cur_syms[k]) begin
         if (idx == total) return;
         s = cur_syms[k];
         e = cur_ext[k];
         val = 0;
         if (s < 16) begin
            run = 1;
            val = s;
         end else if (s == 16) begin
            if (idx == 0) begin
               exp_err = 1;
               return;
            end
            run = 3 + e % 4;
            val = prev;
         end else if (s == 17) begin
            run = 3 + e % 8;
         end else if (s == 18) begin
            run = 11 + e % 128;
         end else begin
            exp_err = 1;
            return;
         end
         if (idx + run > total) begin
            exp_err = 1;
            return;
         end
         repeat (run) exp_q.push_back(val);
         idx += run;
         prev = val;
      end
   endfunction

   // mode: 0 ready always, 1 random, 2 pattern 1,0,0
   task automatic run_case(input string nm, input int total,
                           input int mode, input int tc,
                           input int te, input int ts);
      int k, got, sum, cyc, ph;
      bit fin, stalled;
      logic [3:0] sl;
      logic [8:0] si;
      k = 0; got = 0; sum = 0; cyc = 0; ph = 0;
      fin = 0; stalled = 0; sl = '0; si = '0;
      build_expect(total);
      @(negedge clk);
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      start       = 1'b1;
      total_count = 9'(total);
      @(negedge clk);
      while (!fin && cyc < 3000) begin
         start = 1'b0;
         if (done || error) begin
            fin = 1;
         end else begin
            if (stalled && out_valid) begin
               chk({nm, " stall_len"}, out_len, sl);
               chk({nm, " stall_idx"}, out_index, si);
            end
            if (in_ready && out_valid)
               chk({nm, " ready_in_emit"}, 1, 0);
            unique case (mode)
               0: out_ready = 1'b1;
               1: out_ready = 1'($urandom_range(0, 1));
               default: out_ready = (ph % 3 == 0);
            endcase
            if (out_valid) ph++;
            in_valid = (k < cur_syms.size());
            if (mode == 1 && $urandom_range(0, 3) == 0)
               in_valid = 1'b0;
            in_sym   = in_valid ? 5'(cur_syms[k]) : 5'($urandom);
            in_extra = in_valid ? 7'(cur_ext[k]) : 7'($urandom);
            if (mode == 1 && (in_ready || out_valid)
                && $urandom_range(0, 15) == 0) begin
               start       = 1'b1;
               total_count = 9'd1;
            end
            if (out_valid && out_ready) begin
               chk({nm, " index"}, out_index, got);
               if (got < exp_q.size())
                  chk({nm, " len"}, out_len, exp_q[got]);
               else
                  chk({nm, " extra_output"}, 1, 0);
               sum += int'(out_len);
               got++;
            end
            stalled = out_valid && !out_ready;
            sl = out_len;
            si = out_index;
            if (in_valid && in_ready) k++;
            @(negedge clk);
            cyc++;
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (!fin) chk({nm, " timeout"}, 1, 0);
      chk({nm, " count"}, got, exp_q.size());
      chk({nm, " error"}, error, exp_err);
      chk({nm, " done"}, done, !exp_err);
      chk({nm, " idle_out"}, {in_ready, out_valid}, 0);
      if (tc >= 0) begin
         chk({nm, " tab_count"}, got, tc);
         chk({nm, " tab_error"}, error, te);
         chk({nm, " tab_sum"}, sum, ts);
      end
   endtask

   function automatic vec_t mk(input string nm, input int t, input int m,
      input int n, input int s0, e0, s1, e1, s2, e2, s3, e3, s4, e4,
      input int c, r, sm);
      vec_t v;
      v.nm = nm; v.total = t; v.mode = m; v.n = n;
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3; v.s[4] = s4;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4;
      v.cnt = c; v.err = r; v.sum = sm;
      return v;
   endfunction

   initial begin
      int r, tot, lim;
      reset = 1'b1; start = 1'b0; total_count = '0;
      in_valid = 1'b0; in_sym = '0; in_extra = '0; out_ready = 1'b0;

      tab.push_back(mk("literal", 4, 0, 4, 8,0, 8,0, 9,0, 7,0, 0,0, 4,0,32));
      tab.push_back(mk("repeat", 10, 0, 3, 5,0, 16,2, 17,1, 0,0, 0,0, 10,0,30));
      tab.push_back(mk("overrun140", 140, 0, 3, 18,127, 3,0, 16,0, 0,0, 0,0, 139,1,3));
      tab.push_back(mk("zero_run142", 142, 0, 3, 18,127, 3,0, 16,0, 0,0, 0,0, 142,0,12));
      tab.push_back(mk("first16", 5, 0, 1, 16,0, 0,0, 0,0, 0,0, 0,0, 0,1,0));
      tab.push_back(mk("sym20", 5, 0, 1, 20,0, 0,0, 0,0, 0,0, 0,0, 0,1,0));
      tab.push_back(mk("total0", 0, 0, 0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,0));
      tab.push_back(mk("total321", 321, 0, 0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,0));
      tab.push_back(mk("total320", 320, 0, 5, 18,127, 18,127, 17,7, 16,3, 18,17, 320,0,0));
      tab.push_back(mk("backpress", 7, 2, 2, 4,0, 16,3, 0,0, 0,0, 0,0, 7,0,28));
      tab.push_back(mk("overrun17", 2, 0, 2, 15,0, 17,0, 0,0, 0,0, 0,0, 1,1,15));
      tab.push_back(mk("hi_extra", 4, 0, 2, 1,0, 16,124, 0,0, 0,0, 0,0, 4,0,4));

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst done", done, 0);
      chk("rst error", error, 0);
      chk("rst out_len", out_len, 0);
      chk("rst out_index", out_index, 0);

      foreach (tab[i]) begin
         cur_syms.delete();
         cur_ext.delete();
         for (int j = 0; j < tab[i].n; j++) begin
            cur_syms.push_back(tab[i].s[j]);
            cur_ext.push_back(tab[i].e[j]);
         end
         run_case(tab[i].nm, tab[i].total, tab[i].mode,
                  tab[i].cnt, tab[i].err, tab[i].sum);
      end

      // reset in the middle of a zero run
      @(negedge clk);
      start = 1'b1; total_count = 9'd200; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_sym = 5'd18; in_extra = 7'd50;
      lim = 0;
      while (!(out_valid && out_index == 9'd40) && lim < 200) begin
         @(negedge clk);
         in_valid = 1'b0;
         lim++;
      end
      chk("mid_rst reached40", out_index, 40);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst outs", {in_ready, out_valid, done, error, out_len, out_index}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst idle", {in_ready, out_valid, done, error}, 0);
      cur_syms = {1, 2};
      cur_ext  = {0, 0};
      run_case("post_rst", 2, 0, 2, 0, 3);

      // random streams
      for (int it = 0; it < 30; it++) begin
         tot = (it % 5 == 0) ? $urandom_range(1, 330) : $urandom_range(1, 60);
         cur_syms.delete();
         cur_ext.delete();
         for (int j = 0; j < 400; j++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      cur_syms.push_back($urandom_range(0, 15));
            else if (r < 75) cur_syms.push_back(16);
            else if (r < 85) cur_syms.push_back(17);
            else if (r < 97) cur_syms.push_back(18);
            else             cur_syms.push_back($urandom_range(19, 31));
            cur_ext.push_back((r < 85) ? $urandom_range(0, 127) : $urandom_range(0, 20));
         end
         run_case($sformatf("rand%0d", it), tot, 1, -1, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
